// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU memory stage, the VGA pixel fetcher and the shared data RAM.
// The arbiter takes the slave view; the requesters and the RAM together form the master view.
interface ram_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              cpu_req;
    logic              cpu_we;
    logic [3:0]        cpu_be;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [31:0]       vid_rdata;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid, vid_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between CPU loads/stores and video reads.
// Video has priority; the CPU is forced through after MAX_WAIT stalled cycles.
module ram_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    owner_t     rd_owner_reg;
    owner_t     rd_owner_next;
    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;
    logic       cpu_win;
    logic       vid_win;
    logic       forced;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner_reg <= OWN_NONE;
            wait_cnt_reg <= 4'd0;
        end else begin
            rd_owner_reg <= rd_owner_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        cpu_win       = 1'b0;
        vid_win       = 1'b0;
        forced        = bus.cpu_req && (wait_cnt_reg == MAX_WAIT_C);
        wait_cnt_next = 4'd0;
        rd_owner_next = OWN_NONE;
        if (!rst) begin
            if (bus.vid_req && !forced) begin
                vid_win = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_win = 1'b1;
            end
        end
        // Saturate so a forced grant stays pending until the CPU actually wins.
        if (bus.cpu_req && !cpu_win) begin
            wait_cnt_next = (wait_cnt_reg == MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_reg + 4'd1;
        end
        if (cpu_win && !bus.cpu_we) begin
            rd_owner_next = OWN_CPU;
        end else if (vid_win) begin
            rd_owner_next = OWN_VID;
        end
    end

    assign bus.cpu_gnt   = cpu_win;
    assign bus.vid_gnt   = vid_win;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_win;

    assign bus.ram_en    = cpu_win | vid_win;
    assign bus.ram_addr  = cpu_win ? bus.cpu_addr :
                           vid_win ? bus.vid_addr : '0;
    assign bus.ram_wdata = bus.cpu_wdata;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
            assign bus.ram_we[gi] = cpu_win & bus.cpu_we & bus.cpu_be[gi];
        end
    endgenerate

    // Gating with rst drops a response whose load was granted just before reset.
    assign bus.cpu_rvalid = (rd_owner_reg == OWN_CPU) && !rst;
    assign bus.vid_rvalid = (rd_owner_reg == OWN_VID) && !rst;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_rdata : 32'd0;
    assign bus.vid_rdata  = bus.vid_rvalid ? bus.ram_rdata : 32'd0;
endmodule
